// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types, constants and helpers for the tdm demux
package tdm_pkg;

  localparam int NSLOT = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  // Increment v by one unless it already sits at maxv.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - framing FSM, slot counter and sync-error accounting
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic [1:0]      slot,
  output logic [3:0]      slot_we,
  output logic            frame_done,
  output logic            sync_err,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERRW) - 64'd1);

  tdm_state_e state, state_nxt;
  slot_t      slot_q, slot_nxt;
  logic       err_nxt;

  assign slot = slot_q;

  // State, slot index and error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot_q   <= '0;
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      slot_q   <= slot_nxt;
      sync_err <= err_nxt;
      if (err_nxt) begin
        err_cnt <= ERRW'(sat_inc(32'(err_cnt), ERR_MAX));
      end
    end
  end

  // Next-state decode; a SOF always restarts at slot 0, whatever the state.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_q;
    slot_we    = '0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sof) begin
            slot_we[0] = 1'b1;
            slot_nxt   = 2'd1;
            state_nxt  = RECV;
          end
        end
        RECV: begin
          if (in_sof) begin
            err_nxt    = 1'b1;
            slot_we[0] = 1'b1;
            slot_nxt   = 2'd1;
          end else begin
            slot_we[slot_q] = 1'b1;
            if (slot_q == 2'(NSLOT - 1)) begin
              frame_done = 1'b1;
              slot_nxt   = 2'd0;
              state_nxt  = HUNT;
            end else begin
              slot_nxt = slot_q + 2'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot tdm demultiplexer with atomic frame publish
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W    = 3,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic [W-1:0]    y0,
  output logic [W-1:0]    y1,
  output logic [W-1:0]    y2,
  output logic [W-1:0]    y3,
  output logic            out_valid,
  output logic [1:0]      slot,
  output logic            sync_err,
  output logic [ERRW-1:0] err_cnt
);

  logic [3:0]   slot_we;
  logic         frame_done;
  logic [W-1:0] shadow0, shadow1, shadow2;

  tdm_slot_ctr #(
    .ERRW (ERRW)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .slot       (slot),
    .slot_we    (slot_we),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  // Shadow capture for slots 0..2; slot 3 goes straight to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
    end else begin
      if (slot_we[0]) shadow0 <= in_data;
      if (slot_we[1]) shadow1 <= in_data;
      if (slot_we[2]) shadow2 <= in_data;
    end
  end

  // Publish the whole frame in one edge so no partial frame is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= frame_done;
      if (frame_done) begin
        y0 <= shadow0;
        y1 <= shadow1;
        y2 <= shadow2;
      end
      if (slot_we[3]) y3 <= in_data;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [2:0] in_data;

  logic [2:0] y0, y1, y2, y3;
  logic       out_valid, sync_err;
  logic [1:0] slot;
  logic [1:0] err_cnt;

  logic [2:0] z0, z1, z2, z3;
  logic       z_valid, z_err;
  logic [1:0] z_slot;
  logic [7:0] z_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt = 0;
  int se_cnt = 0;
  int ov_mark, se_mark;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(3), .ERRW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid), .slot(slot),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  tdm_demux4 dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .y0(z0), .y1(z1), .y2(z2), .y3(z3), .out_valid(z_valid), .slot(z_slot),
    .sync_err(z_err), .err_cnt(z_cnt)
  );

  always @(posedge clk) begin
    #2;
    if (out_valid) ov_cnt++;
    if (sync_err) se_cnt++;
    if (out_valid && sync_err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL excl: out_valid and sync_err both high, required not both");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_y(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                         input logic [2:0] e2, input logic [2:0] e3);
    check({tag, ".y"}, {y0, y1, y2, y3}, {e0, e1, e2, e3});
  endtask

  // Called aligned to a negedge; returns at the following negedge.
  task automatic send(input logic sof, input logic [2:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 3'd0;
    idle(2);

    check_y("reset", 3'd0, 3'd0, 3'd0, 3'd0);
    check("reset.ov", out_valid, 0);
    check("reset.se", sync_err, 0);
    check("reset.cnt", err_cnt, 0);
    check("reset.slot", slot, 0);
    rst_n = 1'b1;
    idle(1);

    // one frame, then a back-to-back frame with no bubble
    send(1'b1, 3'd1);
    check("f1.slot1", slot, 1);
    send(1'b0, 3'd2);
    send(1'b0, 3'd3);
    check("f1.slot3", slot, 3);
    check_y("f1.partial", 3'd0, 3'd0, 3'd0, 3'd0);
    check("f1.ov_early", out_valid, 0);
    send(1'b0, 3'd4);
    check("f1.ov", out_valid, 1);
    check_y("f1", 3'd1, 3'd2, 3'd3, 3'd4);
    check("f1.cnt", err_cnt, 0);
    check("f1.slot0", slot, 0);
    send(1'b1, 3'd7);
    check("b2b.ov_low", out_valid, 0);
    send(1'b0, 3'd6);
    send(1'b0, 3'd5);
    check_y("b2b.hold", 3'd1, 3'd2, 3'd3, 3'd4);
    send(1'b0, 3'd4);
    check("b2b.ov", out_valid, 1);
    check_y("b2b", 3'd7, 3'd6, 3'd5, 3'd4);
    check("b2b.se", sync_err, 0);

    // gapped frame
    ov_mark = ov_cnt;
    send(1'b1, 3'd1);
    idle(2);
    check("gap.slot", slot, 1);
    send(1'b0, 3'd2);
    idle(2);
    send(1'b0, 3'd3);
    idle(2);
    check_y("gap.hold", 3'd7, 3'd6, 3'd5, 3'd4);
    send(1'b0, 3'd4);
    check_y("gap", 3'd1, 3'd2, 3'd3, 3'd4);
    idle(1);
    check("gap.ovcount", ov_cnt - ov_mark, 1);

    // premature sof
    ov_mark = ov_cnt;
    se_mark = se_cnt;
    send(1'b1, 3'd1);
    send(1'b0, 3'd2);
    send(1'b1, 3'd5);
    check("pre.se", sync_err, 1);
    check("pre.ov", out_valid, 0);
    check("pre.cnt", err_cnt, 1);
    check("pre.slot", slot, 1);
    send(1'b0, 3'd6);
    check("pre.se_pulse", sync_err, 0);
    send(1'b0, 3'd7);
    send(1'b0, 3'd0);
    check_y("pre", 3'd5, 3'd6, 3'd7, 3'd0);
    idle(1);
    check("pre.ovcount", ov_cnt - ov_mark, 1);
    check("pre.secount", se_cnt - se_mark, 1);

    // hunt drop after reset
    do_reset();
    se_mark = se_cnt;
    send(1'b0, 3'd3);
    send(1'b0, 3'd4);
    check("hunt.slot", slot, 0);
    check("hunt.se", se_cnt - se_mark, 0);
    send(1'b1, 3'd2);
    send(1'b0, 3'd1);
    send(1'b0, 3'd6);
    send(1'b0, 3'd7);
    check_y("hunt", 3'd2, 3'd1, 3'd6, 3'd7);
    check("hunt.cnt", err_cnt, 0);

    // saturation: five premature sofs
    do_reset();
    se_mark = se_cnt;
    send(1'b1, 3'd1);
    for (int i = 0; i < 5; i++) send(1'b1, 3'(i + 2));
    idle(1);
    check("sat.cnt2", err_cnt, 3);
    check("sat.cnt8", z_cnt, 5);
    check("sat.pulses", se_cnt - se_mark, 5);
    send(1'b0, 3'd3);
    send(1'b0, 3'd2);
    send(1'b0, 3'd1);
    check_y("sat", 3'd6, 3'd3, 3'd2, 3'd1);
    check("sat.cnt_hold", err_cnt, 3);

    // async reset mid-frame
    send(1'b1, 3'd4);
    send(1'b0, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_y("arst", 3'd0, 3'd0, 3'd0, 3'd0);
    check("arst.slot", slot, 0);
    check("arst.cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(1'b1, 3'd3);
    send(1'b0, 3'd5);
    send(1'b0, 3'd7);
    send(1'b0, 3'd1);
    check("arst.ov", out_valid, 1);
    check_y("arst.fresh", 3'd3, 3'd5, 3'd7, 3'd1);
    check("arst.cnt8", z_cnt, 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
